// File: rtl/pipe_stage_skid.sv
// Two-entry pipeline stage with a skid buffer: full throughput, registered in_ready,
// flush that inserts a bubble, and a saturating count of flushes that dropped work.
module pipe_stage_skid #(
  parameter int DATA_W     = 32,
  parameter int CTRL_W     = 8,
  parameter int CLEAR_DATA = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [7:0]        drop_count
);

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b01;
  localparam logic [1:0] TWO   = 2'b10;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [7:0]        drop_count_q, drop_count_d;
  logic              push, pop;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // in_ready is a pure decode of the state flops, so it carries no combinational path
  assign in_ready   = ~state_q[1];
  assign out_valid  = (state_q != EMPTY);
  assign out_data   = main_data_q;
  assign out_ctrl   = main_ctrl_q;
  assign drop_count = drop_count_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    state_d      = state_q;
    main_data_d  = main_data_q;
    main_ctrl_d  = main_ctrl_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;
    drop_count_d = drop_count_q;
    if (flush) begin
      // A pop in the flush cycle completed, so only unpopped work counts as dropped
      if ((state_q == TWO) || ((state_q == ONE) && !out_ready))
        drop_count_d = sat_inc(drop_count_q);
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      if (CLEAR_DATA != 0) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
            state_d     = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (push) begin
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
            state_d     = TWO;
          end else if (pop) begin
            main_ctrl_d = '0;
            state_d     = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            state_d     = ONE;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_ctrl_d = '0;
          skid_ctrl_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= EMPTY;
      main_data_q  <= '0;
      main_ctrl_q  <= '0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      main_data_q  <= main_data_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
      drop_count_q <= drop_count_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus random traffic against a
// two-slot queue model, on one instance per CLEAR_DATA setting.
module tb_pipe_stage_skid;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;

  logic              clk, rst, flush, in_valid, out_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              in_ready0, out_valid0, in_ready1, out_valid1;
  logic [DATA_W-1:0] out_data0, out_data1;
  logic [CTRL_W-1:0] out_ctrl0, out_ctrl1;
  logic [7:0]        drop0, drop1;

  int total = 0;
  int bad   = 0;

  logic [DATA_W+CTRL_W-1:0] mq[$];
  int                       mdrop;

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_DATA(0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_ctrl(out_ctrl0), .drop_count(drop0));

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_DATA(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_ctrl(out_ctrl1), .drop_count(drop1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: model follows the queue rules, then outputs settle for sampling.
  task automatic step();
    bit push, pop;
    push = in_valid && (mq.size() < 2);
    pop  = (mq.size() > 0) && out_ready;
    @(posedge clk);
    if (flush) begin
      if (mq.size() == 2 || (mq.size() == 1 && !pop))
        mdrop = (mdrop < 255) ? mdrop + 1 : 255;
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back({in_data, in_ctrl});
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input bit rdy, input bit fl);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = rdy;
    flush     = fl;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, '0, '0, 0, 0);
    #2 rst = 1'b0;
    #2;
    total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid0); end
    total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready0); end
    total++; if (out_data0 !== '0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data0); end
    total++; if (out_ctrl0 !== '0) begin bad++; $display("FAIL reset_out_ctrl got=%h want=0", out_ctrl0); end
    total++; if (drop0 !== 8'd0) begin bad++; $display("FAIL reset_drop got=%0d want=0", drop0); end
    @(posedge clk); #1;
    rst = 1'b1;
    mq.delete();
    mdrop = 0;
  endtask

  task automatic test_basic();
    drive(1, 32'h100, 8'h5A, 1, 0);
    step();
    total++; if (out_valid0 !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", out_valid0); end
    total++; if (out_data0 !== 32'h100) begin bad++; $display("FAIL basic_data got=%h want=100", out_data0); end
    total++; if (out_ctrl0 !== 8'h5A) begin bad++; $display("FAIL basic_ctrl got=%h want=5a", out_ctrl0); end
    drive(0, 32'hDEAD, 8'hFF, 1, 0);
    step();
    total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL basic_bubble_valid got=%b want=0", out_valid0); end
    total++; if (out_ctrl0 !== 8'h00) begin bad++; $display("FAIL basic_bubble_ctrl got=%h want=0", out_ctrl0); end
  endtask

  task automatic test_backpressure();
    drive(1, 32'hA0A0, 8'h11, 0, 0);
    step();
    drive(1, 32'hB0B0, 8'h22, 0, 0);
    step();
    total++; if (in_ready0 !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready0); end
    drive(1, 32'hC0C0, 8'h33, 0, 0);
    step();
    total++; if (out_data0 !== 32'hA0A0 || out_ctrl0 !== 8'h11) begin bad++; $display("FAIL bp_stall got=%h/%h want=a0a0/11", out_data0, out_ctrl0); end
    drive(0, '0, '0, 1, 0);
    #1;
    total++; if (out_valid0 !== 1'b1 || out_data0 !== 32'hA0A0) begin bad++; $display("FAIL bp_first got=%b/%h want=1/a0a0", out_valid0, out_data0); end
    step();
    total++; if (out_valid0 !== 1'b1 || out_data0 !== 32'hB0B0 || out_ctrl0 !== 8'h22) begin bad++; $display("FAIL bp_second got=%b/%h/%h want=1/b0b0/22", out_valid0, out_data0, out_ctrl0); end
    step();
    total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b want=0", out_valid0); end
  endtask

  task automatic test_flush_two();
    drive(1, 32'h1, 8'h01, 0, 0); step();
    drive(1, 32'h2, 8'h02, 0, 0); step();
    drive(1, 32'h3, 8'h03, 0, 1); step();
    total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL flush2_valid got=%b want=0", out_valid0); end
    total++; if (out_ctrl0 !== 8'h00) begin bad++; $display("FAIL flush2_ctrl got=%h want=0", out_ctrl0); end
    total++; if (drop0 !== 8'd1) begin bad++; $display("FAIL flush2_drop got=%0d want=1", drop0); end
    total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL flush2_in_ready got=%b want=1", in_ready0); end
    drive(0, '0, '0, 1, 0); step();
    total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL flush2_ghost got=%b want=0", out_valid0); end
  endtask

  task automatic test_flush_pop();
    drive(1, 32'h1234, 8'h33, 0, 0); step();
    drive(0, '0, '0, 1, 1); step();
    total++; if (drop0 !== 8'd1 || drop1 !== 8'd1) begin bad++; $display("FAIL flushpop_drop got=%0d/%0d want=1/1", drop0, drop1); end
    total++; if (out_data0 !== 32'h1234) begin bad++; $display("FAIL flushpop_hold_data got=%h want=1234", out_data0); end
    total++; if (out_data1 !== 32'h0) begin bad++; $display("FAIL flushpop_clear_data got=%h want=0", out_data1); end
    total++; if (out_ctrl0 !== 8'h00 || out_valid0 !== 1'b0) begin bad++; $display("FAIL flushpop_bubble got=%b/%h want=0/0", out_valid0, out_ctrl0); end
    drive(0, '0, '0, 0, 0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      drive(1, $urandom, 8'($urandom), 0, 0); step();
      drive(0, '0, '0, 0, 1); step();
    end
    drive(0, '0, '0, 0, 0);
    total++; if (drop0 !== 8'd255 || drop1 !== 8'd255) begin bad++; $display("FAIL sat_drop got=%0d/%0d want=255", drop0, drop1); end
    total++; if (int'(drop0) != mdrop) begin bad++; $display("FAIL sat_model got=%0d want=%0d", drop0, mdrop); end
  endtask

  task automatic test_async_reset();
    drive(1, 32'h55, 8'h55, 0, 0); step();
    drive(1, 32'h66, 8'h66, 0, 0); step();
    drive(0, '0, '0, 0, 0);
    total++; if (in_ready0 !== 1'b0) begin bad++; $display("FAIL areset_setup got=%b want=0", in_ready0); end
    #2 rst = 1'b0;
    #1;
    total++; if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin bad++; $display("FAIL areset_hs got=%b/%b want=0/1", out_valid0, in_ready0); end
    total++; if (out_data0 !== '0 || out_ctrl0 !== '0) begin bad++; $display("FAIL areset_payload got=%h/%h want=0/0", out_data0, out_ctrl0); end
    total++; if (drop0 !== 8'd0) begin bad++; $display("FAIL areset_drop got=%0d want=0", drop0); end
    @(posedge clk); #1;
    rst = 1'b1;
    mq.delete();
    mdrop = 0;
    drive(1, 32'h77, 8'h77, 1, 0); step();
    total++; if (out_valid0 !== 1'b1 || out_data0 !== 32'h77) begin bad++; $display("FAIL areset_resume got=%b/%h want=1/77", out_valid0, out_data0); end
    drive(0, '0, '0, 1, 0); step();
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] ed;
    logic [CTRL_W-1:0] ec;
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, 8'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      step();
      ed = '0; ec = '0;
      if (mq.size() > 0) {ed, ec} = mq[0];
      total++;
      if (out_valid0 !== (mq.size() > 0) || in_ready0 !== (mq.size() < 2) ||
          out_valid1 !== (mq.size() > 0) || in_ready1 !== (mq.size() < 2)) begin
        bad++; $display("FAIL rand_hs cyc=%0d got=%b%b/%b%b want_size=%0d", i, out_valid0, in_ready0, out_valid1, in_ready1, mq.size());
      end
      total++;
      if (out_ctrl0 !== ec || out_ctrl1 !== ec) begin
        bad++; $display("FAIL rand_ctrl cyc=%0d got=%h/%h want=%h", i, out_ctrl0, out_ctrl1, ec);
      end
      if (mq.size() > 0) begin
        total++;
        if (out_data0 !== ed || out_data1 !== ed) begin
          bad++; $display("FAIL rand_data cyc=%0d got=%h/%h want=%h", i, out_data0, out_data1, ed);
        end
      end
      total++;
      if (int'(drop0) != mdrop || int'(drop1) != mdrop) begin
        bad++; $display("FAIL rand_drop cyc=%0d got=%0d/%0d want=%0d", i, drop0, drop1, mdrop);
      end
    end
    drive(0, '0, '0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_flush_two();
    test_flush_pop();
    test_saturation();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the datapath payload (PC, operands, immediate, register indices).
REQ-002 SHALL have parameter CTRL_W, default 8: width of the control payload (ALU op, result select, write enables, branch).
REQ-003 SHALL have parameter CLEAR_DATA, default 0: 1 = flush also zeroes data payload; 0 = flush holds data payload.
REQ-004 SHALL have port clk  input  1: single clock, all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port flush  input  1: discard all held entries; inserts a bubble.
REQ-007 SHALL have port in_valid  input  1: upstream entry valid.
REQ-008 SHALL have port in_ready  output  1: stage accepts an entry this cycle; registered.
REQ-009 SHALL have port in_data  input  DATA_W: upstream data payload.
REQ-010 SHALL have port in_ctrl  input  CTRL_W: upstream control payload.
REQ-011 SHALL have port out_valid  output  1: main entry valid.
REQ-012 SHALL have port out_ready  input  1: downstream accepts out_data and out_ctrl.
REQ-013 SHALL have port out_data  output  DATA_W: main entry data payload.
REQ-014 SHALL have port out_ctrl  output  CTRL_W: main entry control payload.
REQ-015 SHALL have port drop_count  output  8: saturating count of flushes that discarded at least one valid entry.

Function
REQ-016 SHALL hold two entries, main (drives outputs) and skid, and SHALL track state EMPTY, ONE or TWO.
REQ-017 SHALL define push as in_valid and in_ready; pop as out_valid and out_ready.
REQ-018 SHALL drive in_ready = 1 in EMPTY and ONE, and 0 in TWO; in_ready SHALL come directly from a flop or from the state encoding.
REQ-019 SHALL drive out_valid = 1 in ONE and TWO.
REQ-020 SHALL, from EMPTY, on push: load main and go to ONE; otherwise stay in EMPTY.
REQ-021 SHALL, from ONE: push with pop loads main and stays ONE; push without pop loads skid and goes TWO; pop without push goes EMPTY; neither holds.
REQ-022 SHALL, from TWO, on pop: move skid to main and go ONE; otherwise hold. No push is possible in TWO.
REQ-023 SHALL give a latency of 1 cycle from push to out_valid when the stage is EMPTY.
REQ-024 SHALL give full throughput: continuous push and pop in ONE moves 1 entry per cycle.
REQ-025 SHALL zero out_ctrl whenever the next state leaves main empty. A bubble SHALL never carry non-zero control.
REQ-026 SHALL let flush have priority over push, pop and all other transitions: next state EMPTY, main and skid control zeroed, push discarded.
REQ-027 SHALL, when CLEAR_DATA=1, zero main and skid data on flush; when CLEAR_DATA=0, hold data on flush.
REQ-028 SHALL treat a pop coinciding with flush as completed; that entry SHALL NOT count as dropped.
REQ-029 SHALL increment drop_count by 1 on a flush when the state is TWO, or when the state is ONE without a coinciding pop; drop_count SHALL saturate at 255.
REQ-030 SHALL keep outputs and entries stable while out_valid=1 and out_ready=0, with no flush.
REQ-031 SHALL ignore in_data and in_ctrl when no push occurs.

Reset
REQ-032 SHALL, on rst low and independent of clk, set state EMPTY, out_valid 0, in_ready 1, out_data 0, out_ctrl 0, skid entry 0 and drop_count 0.
REQ-033 SHALL resume normal operation on the first rising edge after rst deasserts.
REQ-034 SHALL abandon entries held when rst asserts mid-operation; they SHALL NOT count in drop_count.

Verification
REQ-035 SHALL cover basic flow: rst release; push data 0x100 ctrl 0x5A with out_ready=1 -> next cycle out_valid=1, out_data=0x100, out_ctrl=0x5A; next cycle out_valid=0, out_ctrl=0.
REQ-036 SHALL cover backpressure: out_ready=0; push A then B -> in_ready=0 after B; raise out_ready -> A then B delivered on consecutive cycles, no loss, no duplicate.
REQ-037 SHALL cover flush in TWO: flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, drop_count=1, in_ready=1; the pushed entry never appears.
REQ-038 SHALL cover flush with coinciding pop in ONE: drop_count unchanged. With CLEAR_DATA=0, out_data holds its value; with CLEAR_DATA=1, out_data=0.
REQ-039 SHALL cover saturation: 300 flushes each with one valid entry -> drop_count=255.
REQ-040 SHALL cover asynchronous reset: assert rst mid-cycle in TWO -> outputs at reset values before the next clk edge.
